// File: rtl/phase_timer_pkg.sv
// Shared types and defaults for the phase countdown timer.
package phase_timer_pkg;

    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

endpackage

// File: rtl/tick_sync.sv
// Synchronises one divided-clock input and emits a registered one-cycle
// pulse per rising edge, muted until the synchroniser has flushed after reset.
module tick_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic tick_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   arm_q;
    logic                   tick_q;
    logic                   tick_d;

    // arm_q fills with ones after reset; the top bit gates ticks so a level
    // already high at release cannot look like an edge.
    always_comb begin
        tick_d = arm_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            arm_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/phase_timer.sv
// Phase countdown timer: synchronised divided-clock ticks plus a seconds
// countdown with load/start/pause control and a one-cycle expiry pulse.
module phase_timer
    import phase_timer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned TIME_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_1hz,
    input  logic              clk_10hz,
    input  logic              clk_20hz,
    input  logic              clk_40hz,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic              start,
    input  logic              pause,
    output logic              tick_1hz,
    output logic              tick_10hz,
    output logic              tick_20hz,
    output logic              tick_40hz,
    output logic [TIME_W-1:0] remaining,
    output logic              running,
    output logic              done,
    output logic              expired
);

    state_e            state_q, state_d;
    logic [TIME_W-1:0] rem_q, rem_d;
    logic              done_q, done_d;

    tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_1hz (
        .clk(clk), .rst_n(rst_n), .async_i(clk_1hz), .tick_o(tick_1hz)
    );
    tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_10hz (
        .clk(clk), .rst_n(rst_n), .async_i(clk_10hz), .tick_o(tick_10hz)
    );
    tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_20hz (
        .clk(clk), .rst_n(rst_n), .async_i(clk_20hz), .tick_o(tick_20hz)
    );
    tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_40hz (
        .clk(clk), .rst_n(rst_n), .async_i(clk_40hz), .tick_o(tick_40hz)
    );

    // load overrides everything; a tick seen together with pause is dropped.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (load) begin
            rem_d   = load_val;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (rem_q != '0)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (tick_1hz && (rem_q != '0)) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == TIME_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = ST_EXPIRED;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    state_d = ST_EXPIRED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign remaining = rem_q;
    assign running   = (state_q == ST_RUN);
    assign expired   = (state_q == ST_EXPIRED);
    assign done      = done_q;

endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per divided-clock input (legal 2..4).
REQ-002 SHALL have parameter TIME_W, default 8, width of the seconds countdown.
REQ-003 SHALL have port clk  input  1  system clock, all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports clk_1hz, clk_10hz, clk_20hz, clk_40hz  input  1 each  divided square waves from the clock divider, treated as asynchronous to clk.
REQ-006 SHALL have port load  input  1  load load_val into the countdown.
REQ-007 SHALL have port load_val  input  TIME_W  phase duration in seconds.
REQ-008 SHALL have port start  input  1  single-cycle request to begin counting.
REQ-009 SHALL have port pause  input  1  level; counting frozen while high.
REQ-010 SHALL have ports tick_1hz, tick_10hz, tick_20hz, tick_40hz  output  1 each  one-clk pulse per rising edge of the matching input.
REQ-011 SHALL have port remaining  output  TIME_W  seconds left.
REQ-012 SHALL have port running  output  1  high in RUN state only.
REQ-013 SHALL have port done  output  1  one-clk pulse on expiry.
REQ-014 SHALL have port expired  output  1  high in EXPIRED state only.

Function
REQ-015 Each divided input SHALL pass through SYNC_STAGES flops, then rising-edge detection against one further registered sample.
REQ-016 Tick latency SHALL be SYNC_STAGES+1 clk cycles from the input rising edge; exactly one pulse per edge, none on falling edges.
REQ-017 Ticks SHALL be suppressed for the first SYNC_STAGES+1 cycles after reset release (no spurious tick if an input is already high).
REQ-018 State machine SHALL have states IDLE, RUN, PAUSED, EXPIRED.
REQ-019 load SHALL, from any state, set remaining<=load_val and state<=IDLE next cycle; load has priority over start, pause and tick.
REQ-020 IDLE->RUN SHALL occur on start when remaining!=0; start with remaining==0 SHALL be ignored (stay IDLE, no done).
REQ-021 In RUN with pause low, each tick_1hz SHALL decrement remaining by 1.
REQ-022 In RUN, tick_1hz with remaining==1 SHALL set remaining 0, pulse done that same registered cycle, and enter EXPIRED.
REQ-023 RUN->PAUSED SHALL occur when pause is high; a tick_1hz coincident with pause SHALL be dropped.
REQ-024 PAUSED->RUN SHALL occur when pause is low; ticks while PAUSED SHALL be dropped, remaining held.
REQ-025 start in RUN, PAUSED or EXPIRED SHALL be ignored; leaving EXPIRED requires load.
REQ-026 remaining SHALL never wrap below 0; first decrement after start occurs 0..1 s later (free-running 1 Hz phase, accepted).
REQ-027 tick outputs SHALL run in every state, independent of the countdown.

Reset
REQ-028 rst_n low SHALL asynchronously clear: all synchronizer and edge flops 0, state IDLE, remaining 0, all tick outputs, done, running, expired 0.
REQ-029 Reset asserted mid-count SHALL abandon the count with no done pulse.

Structure
REQ-030 Package phase_timer_pkg SHALL hold the state enum and the SYNC_STAGES default.
REQ-031 Sub-module tick_sync (synchronizer + edge detect + post-reset suppression) SHALL be instantiated four times.

Verification
REQ-032 Input clk_40hz rising edge at cycle 100, SYNC_STAGES=2 -> tick_40hz high exactly cycle 103, one cycle wide; no pulse on falling edge.
REQ-033 clk_1hz held high through reset release -> no tick_1hz until its next rising edge.
REQ-034 load_val=3, load, start, three tick_1hz -> remaining 3,2,1,0; done one pulse on third tick; expired high; running low.
REQ-035 remaining=5 in RUN, pause high coincident with tick_1hz -> remaining stays 5, state PAUSED; pause low then tick -> 4.
REQ-036 load_val=0, load, start -> stays IDLE, done never pulses; load coincident with tick in RUN -> remaining=load_val, IDLE.
REQ-037 rst_n low at remaining=2 in RUN -> all outputs 0 asynchronously, no done pulse after release.
